// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: PLL reconfiguration sequencer on CLK_50M.
// Watches an asynchronous mode select. When the synchronised mode differs from the
// last applied one, it writes an Avalon-MM register sequence into the reconfig IP:
// mode (addr 0), fractional K (addr 7), optionally M (addr 4) and N (addr 3), then
// start (addr 2). It then waits for PLL lock and reports done or error.
// Optional feature: define PLL_CFG_MN_EN to add the per-mode M/N ports and the two
// extra writes between K and start.
module pll_cfg_seq #(
    parameter int NUM_MODES    = 2,
    parameter int MODE_W       = 1,
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_HOLDOFF = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                      CLK_50M,
    input  logic                      reset,
    input  logic [MODE_W-1:0]         mode_i,
    input  logic [NUM_MODES*32-1:0]   mode_kfrac,
`ifdef PLL_CFG_MN_EN
    input  logic [NUM_MODES*18-1:0]   mode_m,
    input  logic [NUM_MODES*18-1:0]   mode_n,
`endif
    input  logic                      mgmt_waitrequest,
    output logic                      mgmt_write,
    output logic [5:0]                mgmt_address,
    output logic [31:0]               mgmt_writedata,
    input  logic                      pll_locked,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [MODE_W-1:0]         applied_mode
);

    localparam int CNT_MAX = (LOCK_TIMEOUT > LOCK_HOLDOFF) ? LOCK_TIMEOUT : LOCK_HOLDOFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  HOLDOFF_C   = CNT_W'(LOCK_HOLDOFF);
    localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(LOCK_TIMEOUT);
    localparam logic [MODE_W:0]   NUM_MODES_C = (MODE_W + 1)'(NUM_MODES);

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_K     = 6'd7;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_START = 6'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_K,
        S_WR_M,
        S_WR_N,
        S_WR_START,
        S_WAIT_LOCK
    } state_t;

    state_t              state;
    state_t              wr_next;
    logic [MODE_W-1:0]   tgt;
    logic [CNT_W-1:0]    cnt;

    logic [MODE_W-1:0]   mode_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [MODE_W-1:0]   ms;
    logic                locked_s;

    logic [31:0]         k_sel;
    logic [5:0]          wr_addr;
    logic [31:0]         wr_data;
`ifdef PLL_CFG_MN_EN
    logic [17:0]         m_sel;
    logic [17:0]         n_sel;
`endif

    // Bring the asynchronous mode select and lock indication into the CLK_50M domain.
    always_ff @(posedge CLK_50M) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // the pre-edge value of its neighbour; blocking here would collapse the chain.
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) mode_sync[i] <= '0;
            lock_sync <= '0;
        end else begin
            mode_sync[0] <= mode_i;
            for (int i = 1; i < SYNC_STAGES; i++) mode_sync[i] <= mode_sync[i-1];
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign ms       = mode_sync[SYNC_STAGES-1];
    assign locked_s = lock_sync[SYNC_STAGES-1];

    // Pick the per-mode constants of the latched target mode (never the live mode).
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves it
        // unassigned and no latch is inferred.
        k_sel = '0;
`ifdef PLL_CFG_MN_EN
        m_sel = '0;
        n_sel = '0;
`endif
        for (int m = 0; m < NUM_MODES; m++) begin
            if (tgt == MODE_W'(m)) begin
                k_sel = mode_kfrac[m*32 +: 32];
`ifdef PLL_CFG_MN_EN
                m_sel = mode_m[m*18 +: 18];
                n_sel = mode_n[m*18 +: 18];
`endif
            end
        end
    end

    // Register address, data and successor for each write state of the sequence.
    always_comb begin
        wr_addr = ADDR_MODE;
        wr_data = '0;
        wr_next = S_IDLE;
        case (state)
            S_WR_MODE: begin
                wr_addr = ADDR_MODE;
                wr_next = S_WR_K;
            end
            S_WR_K: begin
                wr_addr = ADDR_K;
                wr_data = k_sel;
`ifdef PLL_CFG_MN_EN
                wr_next = S_WR_M;
`else
                wr_next = S_WR_START;
`endif
            end
`ifdef PLL_CFG_MN_EN
            S_WR_M: begin
                wr_addr = ADDR_M;
                wr_data = {14'd0, m_sel};
                wr_next = S_WR_N;
            end
            S_WR_N: begin
                wr_addr = ADDR_N;
                wr_data = {14'd0, n_sel};
                wr_next = S_WR_START;
            end
`endif
            S_WR_START: begin
                wr_addr = ADDR_START;
                wr_next = S_WAIT_LOCK;
            end
            default: ;
        endcase
    end

    // Sequencer: request detection, Avalon writes with one idle cycle between them,
    // lock wait with hold-off and timeout, and the registered status outputs.
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state          <= S_IDLE;
            tgt            <= '0;
            cnt            <= '0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            applied_mode   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Only the value seen here matters; changes during a sequence
                    // are collapsed into whatever ms holds on return to IDLE.
                    if (ms != applied_mode) begin
                        if ({1'b0, ms} >= NUM_MODES_C) begin
                            err <= 1'b1;
                        end else begin
                            tgt   <= ms;
                            busy  <= 1'b1;
                            state <= S_WR_MODE;
                        end
                    end
                end

                S_WR_MODE, S_WR_K, S_WR_M, S_WR_N, S_WR_START: begin
                    // Strobe low means this write has not been issued yet; the cycle
                    // after a completed transfer is therefore always an idle one.
                    if (!mgmt_write) begin
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= wr_addr;
                        mgmt_writedata <= wr_data;
                    end else if (!mgmt_waitrequest) begin
                        mgmt_write <= 1'b0;
                        state      <= wr_next;
                        if (state == S_WR_START) begin
                            applied_mode <= tgt;
                            cnt          <= '0;
                        end
                    end
                end

                S_WAIT_LOCK: begin
                    // The counter stops at LOCK_TIMEOUT because that value exits the
                    // state, so it can never wrap.
                    if (locked_s && (cnt >= HOLDOFF_C)) begin
                        done  <= 1'b1;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt >= TIMEOUT_C) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
